// File: rtl/cmp_pkg.sv
// Shared types for the streaming comparator: FSM states and the per-word
// compare result.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_res_t;

endpackage

// File: rtl/word_cmp.sv
// Combinational compare of one word pair, unsigned or two's-complement.
module word_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output cmp_res_t         res
);

    logic a_lt_b;
    logic a_eq_b;

    always_comb begin
        a_eq_b = (a == b);
        // Differing sign bits decide a signed compare; otherwise magnitude order matches.
        if (sgn && (a[WIDTH-1] != b[WIDTH-1])) begin
            a_lt_b = a[WIDTH-1];
        end else begin
            a_lt_b = (a < b);
        end
        res.eq = a_eq_b;
        res.lt = !a_eq_b && a_lt_b;
        res.gt = !a_eq_b && !a_lt_b;
    end

endmodule

// File: rtl/stream_cmp.sv
// Packet-level comparator of two word streams: equality, lexicographic order,
// mismatch count and first differing index, framed by start/done.
module stream_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sgn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic [LEN_W-1:0] mismatch_cnt,
    output logic [LEN_W-1:0] first_idx
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] One    = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] first_q, first_d;
    logic             sgn_q, sgn_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    cmp_res_t         word_res;

    word_cmp #(
        .WIDTH(WIDTH)
    ) u_word_cmp (
        .a  (x),
        .b  (y),
        .sgn(sgn_q),
        .res(word_res)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        sgn_d   = sgn_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    first_d = '0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    sgn_d   = sgn;
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        len_d   = (len > MaxLen) ? MaxLen : len;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (!word_res.eq) begin
                        cnt_d = cnt_q + One;
                        // eq_q still high means no earlier difference in this packet.
                        if (eq_q) begin
                            eq_d    = 1'b0;
                            first_d = idx_q;
                            lt_d    = word_res.lt;
                            gt_d    = word_res.gt;
                        end
                    end
                    idx_d = idx_q + One;
                    if (idx_q == len_q - One) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            sgn_q   <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            sgn_q   <= sgn_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    assign in_ready     = (state_q == RUN);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign eq           = eq_q;
    assign lt           = lt_q;
    assign gt           = gt_q;
    assign mismatch_cnt = cnt_q;
    assign first_idx    = first_q;

endmodule

// File: tb/tb_stream_cmp.sv
// Self-checking bench for stream_cmp: directed cases plus random packets
// checked against a packet-level reference model.
module tb_stream_cmp;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic       sgn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       eq;
    logic       lt;
    logic       gt;
    logic [4:0] mismatch_cnt;
    logic [4:0] first_idx;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    logic [7:0] xs [0:31];
    logic [7:0] ys [0:31];

    stream_cmp #(
        .WIDTH  (8),
        .MAX_LEN(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .sgn         (sgn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt),
        .mismatch_cnt(mismatch_cnt),
        .first_idx   (first_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: walk the first min(len, 16) pairs; first difference decides order.
    task automatic model(input int l, input bit s, output bit e, output bit lo, output bit go,
                         output int cnt, output int fi);
        int n;
        n   = (l > 16) ? 16 : l;
        e   = 1'b1;
        lo  = 1'b0;
        go  = 1'b0;
        cnt = 0;
        fi  = 0;
        for (int i = 0; i < n; i++) begin
            if (xs[i] != ys[i]) begin
                cnt++;
                if (e) begin
                    e  = 1'b0;
                    fi = i;
                    if (s) lo = ($signed(xs[i]) < $signed(ys[i]));
                    else   lo = (xs[i] < ys[i]);
                    go = !lo;
                end
            end
        end
    endtask

    // vmode: 0 continuous valid, 1 fixed pattern 1,0,0,1,0,1, 2 random gaps.
    task automatic run_pkt(input string tag, input int l, input bit s, input int vmode,
                           input bit poke);
        int  n, b, cyc, cnt, fi;
        bit  e, lo, go, v, acc;
        n = (l > 16) ? 16 : l;
        model(l, s, e, lo, go, cnt, fi);
        @(posedge clk); #1;
        start    = 1'b1;
        len      = 5'(l);
        sgn      = s;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ":in_ready_after_start"}, in_ready, n != 0);
        chk({tag, ":busy_after_start"}, busy, 1);
        b   = 0;
        cyc = 0;
        while (!done && cyc < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((cyc % 6) inside {0, 3, 5});
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            x        = xs[b];
            y        = ys[b];
            start    = poke && (cyc == 1);
            len      = 5'd1;
            acc      = v && in_ready;
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            if (acc) b++;
            cyc++;
        end
        chk({tag, ":done"}, done, 1);
        chk({tag, ":beats"}, b, n);
        if (vmode == 0) chk({tag, ":latency"}, cyc, n);
        chk({tag, ":in_ready_in_done"}, in_ready, 0);
        chk({tag, ":eq"}, eq, e);
        chk({tag, ":lt"}, lt, lo);
        chk({tag, ":gt"}, gt, go);
        chk({tag, ":mismatch_cnt"}, mismatch_cnt, cnt);
        chk({tag, ":first_idx"}, first_idx, fi);
        chk({tag, ":onehot"}, 32'(eq) + 32'(lt) + 32'(gt), 1);
        @(posedge clk); #1;
        chk({tag, ":done_pulse"}, done, 0);
        chk({tag, ":idle"}, busy, 0);
        chk({tag, ":hold_eq"}, eq, e);
        chk({tag, ":hold_cnt"}, mismatch_cnt, cnt);
    endtask

    task automatic load4(input logic [31:0] xw, input logic [31:0] yw);
        for (int i = 0; i < 32; i++) begin
            xs[i] = 8'h00;
            ys[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) begin
            xs[i] = xw[31-8*i -: 8];
            ys[i] = yw[31-8*i -: 8];
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        sgn      = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        #1;
        chk("reset:in_ready", in_ready, 0);
        chk("reset:busy", busy, 0);
        chk("reset:done", done, 0);
        chk("reset:eq", eq, 0);
        chk("reset:lt", lt, 0);
        chk("reset:gt", gt, 0);
        chk("reset:mismatch_cnt", mismatch_cnt, 0);
        chk("reset:first_idx", first_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        load4(32'h01020304, 32'h01020304);
        run_pkt("equal4", 4, 1'b0, 0, 1'b0);

        load4(32'h05090007, 32'h05030107);
        run_pkt("gt4", 4, 1'b0, 0, 1'b0);

        load4(32'hFF000000, 32'h01000000);
        run_pkt("signed_lt", 1, 1'b1, 0, 1'b0);
        run_pkt("unsigned_gt", 1, 1'b0, 0, 1'b0);

        load4(32'h10203000, 32'h10803000);
        run_pkt("len3_nogap", 3, 1'b0, 0, 1'b0);
        run_pkt("len3_gaps", 3, 1'b0, 1, 1'b0);

        run_pkt("len0", 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 32; i++) begin
            xs[i] = 8'(i);
            ys[i] = (i == 15) ? 8'hF0 : 8'(i);
        end
        ys[18] = 8'hAA;
        run_pkt("len20_clamp", 20, 1'b1, 0, 1'b0);

        load4(32'h11223344, 32'h11223355);
        run_pkt("start_in_run", 4, 1'b0, 0, 1'b1);

        // Abort a packet after two beats with an asynchronous reset.
        load4(32'h09020304, 32'h01020304);
        @(posedge clk); #1;
        start = 1'b1;
        len   = 5'd4;
        sgn   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x        = xs[i];
            y        = ys[i];
            @(posedge clk); #1;
        end
        chk("pre_rst:mismatch_cnt", mismatch_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        in_valid = 1'b0;
        chk("mid_rst:in_ready", in_ready, 0);
        chk("mid_rst:busy", busy, 0);
        chk("mid_rst:eq", eq, 0);
        chk("mid_rst:gt", gt, 0);
        chk("mid_rst:lt", lt, 0);
        chk("mid_rst:mismatch_cnt", mismatch_cnt, 0);
        chk("mid_rst:first_idx", first_idx, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst:no_done", done, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst:no_done", done, 0);
        run_pkt("post_rst_pkt", 4, 1'b0, 0, 1'b0);

        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 32; i++) begin
                xs[i] = 8'($urandom);
                ys[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : xs[i];
            end
            run_pkt("random", int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 2, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stream_cmp.md
# stream_cmp

- Parametrised, sequential successor to the team's 2-bit equality comparator.
- Compares two word streams X and Y, one WIDTH-bit word pair per accepted beat, over a programmed packet length.
- Reports for the whole packet: equality, lexicographic ordering (first differing word decides), mismatch count and index of the first difference.
- Sits between a pair of stream sources and the checker/scoreboard logic; a start/done pair frames each packet.

## Interface
Parameters:
- WIDTH, 8, word width in bits (≥1).
- MAX_LEN, 16, maximum packet length in words (≥1).
- LEN_W, $clog2(MAX_LEN+1), width of len, idx and count fields (derived, do not override).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin packet; sampled only in IDLE.
- len  in  LEN_W  packet length in words; sampled with start.
- sgn  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- in_valid  in  1  x/y word pair valid.
- in_ready  out  1  block accepts a beat; high only in RUN.
- x  in  WIDTH  stream X word.
- y  in  WIDTH  stream Y word.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, results final.
- eq  out  1  all compared words equal.
- lt  out  1  X < Y at first differing word.
- gt  out  1  X > Y at first differing word.
- mismatch_cnt  out  LEN_W  number of differing word pairs.
- first_idx  out  LEN_W  index (0-based) of first differing pair; 0 if none.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, len≠0:
  - latch len (clamp to MAX_LEN if larger) and sgn;
  - clear idx, mismatch_cnt, first_idx; set eq=1, lt=0, gt=0;
  - go to RUN.
- IDLE, start=1, len=0: go to DONE directly with eq=1, lt=gt=0, counts 0.
- start outside IDLE: ignored.
- RUN: a beat is accepted when in_valid && in_ready. Per accepted beat, via word_cmp on (x, y, latched sgn):
  - If x≠y: mismatch_cnt++.
  - If x≠y and first difference so far: eq←0, first_idx←idx, lt/gt←word result.
  - Later differences do not alter lt/gt/first_idx.
  - idx++. When the beat with idx = len−1 is accepted, go to DONE.
- RUN with in_valid=0: hold state; no counter moves.
- DONE: done=1 for exactly one cycle, then IDLE.
- eq/lt/gt/mismatch_cnt/first_idx:
  - hold their final values from DONE until the next accepted start;
  - during RUN they show running partial values and are not final;
  - exactly one of eq, lt, gt is 1 whenever done=1.
- mismatch_cnt cannot overflow: LEN_W covers MAX_LEN.

## Timing
- Reset (async assert, any state): state IDLE; in_ready, busy, done, lt, gt, mismatch_cnt, first_idx = 0; eq = 0.
- Reset mid-RUN aborts the packet; no done is produced.
- start accepted at edge N → in_ready=1 from cycle N+1.
- Final beat accepted at edge M → done=1 in cycle M+1, with results final in that cycle. in_ready falls in cycle M+1.
- Throughput: one word per cycle, so a len-word packet with continuous valid gives done len+1 cycles after start.
- The earliest next start is the cycle after done (IDLE).
- len=0: done one cycle after start.
- in_ready has no combinational dependence on in_valid.

## Structure
- Package cmp_pkg:
  - state enum {IDLE, RUN, DONE};
  - cmp_res_t struct {eq, lt, gt}.
- Sub-module word_cmp:
  - combinational;
  - parameter WIDTH;
  - inputs a, b, sgn; output cmp_res_t.
  - The signed path compares MSBs first, then magnitude.
- stream_cmp holds the FSM, idx counter, latched len/sgn and result registers.

## Test plan
- WIDTH=8, len=4, sgn=0, X=Y={1,2,3,4}, continuous valid → done 5 cycles after start; eq=1, mismatch_cnt=0, first_idx=0.
- len=4, sgn=0, X={5,9,0,7}, Y={5,3,1,7} → gt=1, first_idx=1, mismatch_cnt=2.
- Signed mode: X={8'hFF}, Y={8'h01}, len=1:
  - sgn=1 → lt=1;
  - same data, sgn=0 → gt=1.
- len=3 with in_valid gaps (valid pattern 1,0,0,1,0,1) → only 3 beats counted; done the cycle after the third accept; results unchanged vs. gap-free run.
- Boundary cases:
  - len=0 → done next cycle, eq=1.
  - len=20 with MAX_LEN=16 → exactly 16 beats consumed.
  - start pulsed during RUN → ignored.
- rst asserted mid-RUN after 2 beats → all outputs 0 immediately (async), no done; a fresh packet afterwards completes correctly.
